meta_merge_arbiter: RTL
=======================

META_MERGE_ARBITER -- requirements
Module: meta_merge_arbiter

Interface
REQ-001 SHALL have parameter META_W, default $bits(metadata_t), the width of one metadata flit.
REQ-002 SHALL have parameter N_IN, default 4, the number of input metadata channels (forward, reorder, scheduler, out).
REQ-003 SHALL have port Clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_meta_data  input  N_IN*META_W  input flits; slice i is channel i.
REQ-006 SHALL have port in_meta_valid  input  N_IN  per-channel valid.
REQ-007 SHALL have port in_meta_ready  output  N_IN  per-channel ready.
REQ-008 SHALL have port out_meta_data  output  META_W  merged flit.
REQ-009 SHALL have port out_meta_valid  output  1  merged valid.
REQ-010 SHALL have port out_meta_ready  input  1  downstream ready.
REQ-011 SHALL have port out_meta_almost_full  input  1  downstream throttle.
REQ-012 SHALL have port stats_in_meta  output  32  accepted input flits, all channels.
REQ-013 SHALL have port stats_out_meta  output  32  delivered output flits.

Function
REQ-014 SHALL transfer on channel i when in_meta_valid[i] and in_meta_ready[i] are both 1 at a posedge; output transfers when out_meta_valid and out_meta_ready are both 1.
REQ-015 SHALL hold a 2-entry in-order output FIFO; occupancy occ ranges 0..2.
REQ-016 SHALL compute can_accept = ~out_meta_almost_full & (occ < 2), from registered state only (no ready-to-ready combinational path).
REQ-017 SHALL grant at most one channel per cycle: the first valid channel scanning from rr_ptr upward, mod N_IN.
REQ-018 SHALL drive in_meta_ready[i] = 1 only for the granted channel and only when can_accept; all other bits are 0.
REQ-019 SHALL update rr_ptr to (granted index + 1) mod N_IN on an accepted input transfer; otherwise rr_ptr holds.
REQ-020 SHALL write the accepted flit into the FIFO tail, giving 1-cycle latency: the flit appears on out_meta_data with out_meta_valid=1 in the cycle after acceptance when occ was 0.
REQ-021 SHALL drive out_meta_valid = (occ != 0) and out_meta_data = FIFO head; both are held stable while out_meta_ready=0.
REQ-022 SHALL update occupancy as follows: push with simultaneous pop leaves occ unchanged; push alone gives occ+1; pop alone gives occ-1; pop at occ=0 is impossible.
REQ-023 SHALL never drop, duplicate or reorder flits; per-channel order is preserved end to end.
REQ-024 SHALL pass data through unchanged; the block neither inspects nor modifies any metadata field.
REQ-025 SHALL increment stats_in_meta by 1 per accepted input transfer and stats_out_meta by 1 per output transfer; both are registered and wrap modulo 2^32 (0xFFFFFFFF+1 = 0).
REQ-026 SHALL, when out_meta_almost_full=1, accept no new input while still draining buffered flits to the output.

Reset
REQ-027 SHALL, on Rst_n=0, asynchronously clear occ, rr_ptr, stats_in_meta and stats_out_meta to 0, giving out_meta_valid=0 and in_meta_ready=0.
REQ-028 SHALL, on reset asserted mid-stream, discard buffered flits; the first flit after release comes from post-reset input only.
REQ-029 SHALL deassert all outputs to their reset values within the reset assertion with no clock edge required; normal operation begins at the first posedge with Rst_n=1.

Verification
REQ-030 SHALL pass this reset check: Rst_n=0 with random inputs -> out_meta_valid=0, in_meta_ready=4'b0000, both stats=0.
REQ-031 SHALL pass this single-source check: channel 2 sends flits A,B,C back-to-back with out_meta_ready=1 -> output A,B,C in consecutive cycles, first one cycle after acceptance, stats_in_meta=stats_out_meta=3.
REQ-032 SHALL pass this fairness check: all four channels continuously valid with out_meta_ready=1 -> grant order 0,1,2,3,0,1,... and one flit per cycle.
REQ-033 SHALL pass this backpressure check: out_meta_ready=0 with channels 0 and 1 valid -> two flits accepted, then in_meta_ready=0; on out_meta_ready=1, channel-0 flit then channel-1 flit emerge; stats_in_meta=2 before drain.
REQ-034 SHALL pass this throttle check: out_meta_almost_full=1 with occ=1 and all inputs valid -> no input accepted, buffered flit still delivered, occ reaches 0.
REQ-035 SHALL pass this counter-wrap check: stats preloaded to 0xFFFFFFFF by forcing, then one transfer -> both counters read 0.

Source files
------------

// File: rtl/meta_merge_arbiter.sv
// ---------------------------------------------------------------------------
// meta_merge_arbiter
//   Merges N_IN metadata channels onto one output stream. A round-robin
//   arbiter picks one valid channel per cycle. The chosen flit goes into a
//   2-entry in-order FIFO that drives the output. Payload bits are carried
//   opaquely and are never inspected.
//
// Ports
//   Clk, Rst_n            clock, async active-low reset
//   in_meta_data          N_IN packed flits, slice i = channel i
//   in_meta_valid/ready   per-channel handshake
//   out_meta_data/valid   merged stream (FIFO head)
//   out_meta_ready        downstream ready
//   out_meta_almost_full  downstream throttle; blocks new acceptance only
//   stats_in_meta         accepted input flits (wraps at 2^32)
//   stats_out_meta        delivered output flits (wraps at 2^32)
// ---------------------------------------------------------------------------
package meta_merge_pkg;
  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  qid;
    logic [15:0] tag;
  } metadata_t;
endpackage

module meta_merge_arbiter #(
  parameter int META_W = $bits(meta_merge_pkg::metadata_t),
  parameter int N_IN   = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [N_IN*META_W-1:0] in_meta_data,
  input  logic [N_IN-1:0]        in_meta_valid,
  output logic [N_IN-1:0]        in_meta_ready,
  output logic [META_W-1:0]      out_meta_data,
  output logic                   out_meta_valid,
  input  logic                   out_meta_ready,
  input  logic                   out_meta_almost_full,
  output logic [31:0]            stats_in_meta,
  output logic [31:0]            stats_out_meta
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0][META_W-1:0] din_arr;
  assign din_arr = in_meta_data;

  // State
  logic [1:0]              occ_q, occ_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    rd_q, rd_d;
  logic [1:0][META_W-1:0]  mem_q;
  logic [31:0]             stats_in_q, stats_out_q;

  // Arbitration
  logic                    gnt_vld;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    can_accept;
  logic                    push, pop;
  logic                    wr_idx;

  // Two descending scans. The second scan covers channels at or above
  // rr_ptr and overrides the first. The result is the lowest valid index
  // >= rr_ptr, or, failing that, the lowest valid index below rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (in_meta_valid[i] && (i < int'(rr_ptr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (in_meta_valid[i] && (i >= int'(rr_ptr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

  // can_accept looks only at registered occupancy and the throttle. A pop in
  // the same cycle does not free a slot, so ready never depends on
  // out_meta_ready. Rst_n gates it so ready stays low while reset is held.
  assign can_accept = Rst_n & ~out_meta_almost_full & (occ_q != 2'd2);
  assign push       = can_accept & gnt_vld;
  assign pop        = (occ_q != 2'd0) & out_meta_ready;
  assign wr_idx     = rd_q ^ occ_q[0];

  always_comb begin
    in_meta_ready = '0;
    if (push) in_meta_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    occ_d    = occ_q;
    rr_ptr_d = rr_ptr_q;
    rd_d     = rd_q ^ pop;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (push) rr_ptr_d = (gnt_idx == IDX_W'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      occ_q       <= '0;
      rr_ptr_q    <= '0;
      rd_q        <= 1'b0;
      stats_in_q  <= '0;
      stats_out_q <= '0;
    end else begin
      occ_q    <= occ_d;
      rr_ptr_q <= rr_ptr_d;
      rd_q     <= rd_d;
      if (push) stats_in_q  <= stats_in_q + 32'd1;
      if (pop)  stats_out_q <= stats_out_q + 32'd1;
    end
  end

  // The FIFO storage is also cleared, so out_meta_data reads 0 in reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_q <= '0;
    end else if (push) begin
      mem_q[wr_idx] <= din_arr[gnt_idx];
    end
  end

  assign out_meta_valid = (occ_q != 2'd0);
  assign out_meta_data  = mem_q[rd_q];
  assign stats_in_meta  = stats_in_q;
  assign stats_out_meta = stats_out_q;

endmodule
